// File: rtl/rv_isa_pkg.sv
`default_nettype none
// ============================================================================
// rv_isa_pkg : shared RV32I opcodes, instruction format enum, immediate ranges
// Rev 1.0
// ============================================================================
package rv_isa_pkg;

   localparam logic [6:0] MEM_LOAD      = 7'b0000011;
   localparam logic [6:0] MEM_STORE     = 7'b0100011;
   localparam logic [6:0] R_TYPE        = 7'b0110011;
   localparam logic [6:0] INT_IMMEDIATE = 7'b0010011;
   localparam logic [6:0] BRANCH        = 7'b1100011;
   localparam logic [6:0] JAL           = 7'b1101111;
   localparam logic [6:0] JALR          = 7'b1100111;

   typedef enum logic [2:0] {
      FMT_R = 3'd0,
      FMT_I = 3'd1,
      FMT_S = 3'd2,
      FMT_B = 3'd3,
      FMT_J = 3'd4
   } instr_fmt_e;

   // Signed byte-offset limits; B and J offsets must additionally be even
   localparam int IMM12_MIN = -2048;
   localparam int IMM12_MAX = 2047;
   localparam int IMM_B_MIN = -4096;
   localparam int IMM_B_MAX = 4094;
   localparam int IMM_J_MIN = -(1 << 20);
   localparam int IMM_J_MAX = (1 << 20) - 2;

endpackage
`default_nettype wire

// File: rtl/instr_word_pack.sv
`default_nettype none
// ============================================================================
// instr_word_pack : combinational RV32I field packer with immediate range check
// Rev 1.0
// ============================================================================
module instr_word_pack
   import rv_isa_pkg::*;
#(
   parameter int DATA_WIDTH    = 32,
   parameter int OP_CODE_WIDTH = 7,
   parameter int FUNCT3_WIDTH  = 3,
   parameter int FUNCT7_WIDTH  = 7
) (
   input  logic [2:0]               fmt,
   input  logic [OP_CODE_WIDTH-1:0] op_code,
   input  logic [FUNCT3_WIDTH-1:0]  funct3,
   input  logic [FUNCT7_WIDTH-1:0]  funct7,
   input  logic [4:0]               rd,
   input  logic [4:0]               rs1,
   input  logic [4:0]               rs2,
   input  logic [31:0]              imm,
   output logic [DATA_WIDTH-1:0]    word,
   output logic                     legal
);

   logic signed [31:0] w_simm;

   always_comb begin
      w_simm = imm;
      word   = '0;
      legal  = 1'b0;
      case (fmt)
         FMT_R: begin
            word  = {funct7, rs2, rs1, funct3, rd, op_code};
            legal = 1'b1;
         end
         FMT_I: begin
            word  = {imm[11:0], rs1, funct3, rd, op_code};
            legal = (w_simm >= IMM12_MIN) && (w_simm <= IMM12_MAX);
         end
         FMT_S: begin
            word  = {imm[11:5], rs2, rs1, funct3, imm[4:0], op_code};
            legal = (w_simm >= IMM12_MIN) && (w_simm <= IMM12_MAX);
         end
         FMT_B: begin
            word  = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], op_code};
            legal = (w_simm >= IMM_B_MIN) && (w_simm <= IMM_B_MAX) && !imm[0];
         end
         FMT_J: begin
            word  = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op_code};
            legal = (w_simm >= IMM_J_MIN) && (w_simm <= IMM_J_MAX) && !imm[0];
         end
         default: begin
            word  = '0;
            legal = 1'b0;
         end
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/instr_encoder.sv
`default_nettype none
// ============================================================================
// instr_encoder : descriptor-driven RV32I encoder writing consecutive imem words
// Rev 1.0
// ============================================================================
module instr_encoder
   import rv_isa_pkg::*;
#(
   parameter int DATA_WIDTH    = 32,
   parameter int ADDR_WIDTH    = 10,
   parameter int OP_CODE_WIDTH = 7,
   parameter int FUNCT3_WIDTH  = 3,
   parameter int FUNCT7_WIDTH  = 7
) (
   input  logic                     i_clk,
   input  logic                     i_reset_n,
   input  logic                     i_start,
   input  logic [ADDR_WIDTH-1:0]    i_base_addr,
   input  logic [ADDR_WIDTH:0]      i_length,
   input  logic                     i_valid,
   output logic                     o_ready,
   input  logic [2:0]               i_fmt,
   input  logic [OP_CODE_WIDTH-1:0] i_op_code,
   input  logic [FUNCT3_WIDTH-1:0]  i_funct3,
   input  logic [FUNCT7_WIDTH-1:0]  i_funct7,
   input  logic [4:0]               i_rd,
   input  logic [4:0]               i_rs1,
   input  logic [4:0]               i_rs2,
   input  logic [31:0]              i_imm,
   output logic                     o_mem_wr_en,
   output logic [ADDR_WIDTH-1:0]    o_mem_addr,
   output logic [DATA_WIDTH-1:0]    o_mem_wr_data,
   output logic                     o_busy,
   output logic                     o_done,
   output logic                     o_err,
   output logic [ADDR_WIDTH:0]      o_count
);

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_RUN  = 1'b1;

   logic [0:0]            r_state;
   logic [0:0]            w_next_state;
   logic [ADDR_WIDTH-1:0] r_base;
   logic [ADDR_WIDTH:0]   r_length;
   logic [ADDR_WIDTH:0]   r_accepted;
   logic [ADDR_WIDTH:0]   r_count;
   logic                  r_wr_en;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [DATA_WIDTH-1:0] r_data;
   logic                  r_done;
   logic                  r_err;
   logic [DATA_WIDTH-1:0] w_word;
   logic                  w_legal;
   logic                  w_hs;

   instr_word_pack #(
      .DATA_WIDTH    (DATA_WIDTH),
      .OP_CODE_WIDTH (OP_CODE_WIDTH),
      .FUNCT3_WIDTH  (FUNCT3_WIDTH),
      .FUNCT7_WIDTH  (FUNCT7_WIDTH)
   ) u_pack (
      .fmt     (i_fmt),
      .op_code (i_op_code),
      .funct3  (i_funct3),
      .funct7  (i_funct7),
      .rd      (i_rd),
      .rs1     (i_rs1),
      .rs2     (i_rs2),
      .imm     (i_imm),
      .word    (w_word),
      .legal   (w_legal)
   );

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) r_state <= S_IDLE;
      else            r_state <= w_next_state;
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE: if (i_start && (i_length != '0)) w_next_state = S_RUN;
         S_RUN: begin
            if (i_start)     w_next_state = (i_length != '0) ? S_RUN : S_IDLE;
            else if (r_done) w_next_state = S_IDLE;
         end
         default: w_next_state = S_IDLE;
      endcase
   end

   always_comb begin
      o_busy  = (r_state == S_RUN);
      o_ready = (r_state == S_RUN) && (r_accepted < r_length);
   end

   assign w_hs = i_valid && o_ready;

   // A new start wins over a same-cycle handshake; an already-registered write still drains
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_base     <= '0;
         r_length   <= '0;
         r_accepted <= '0;
         r_count    <= '0;
         r_wr_en    <= 1'b0;
         r_addr     <= '0;
         r_data     <= '0;
         r_done     <= 1'b0;
         r_err      <= 1'b0;
      end else begin
         r_wr_en <= 1'b0;
         r_done  <= 1'b0;
         if (i_start) begin
            r_base     <= i_base_addr;
            r_length   <= i_length;
            r_accepted <= '0;
            r_count    <= '0;
            r_err      <= 1'b0;
            r_done     <= (i_length == '0);
         end else begin
            if (r_wr_en) r_count <= r_count + 1'b1;
            if (w_hs) begin
               if (w_legal) begin
                  r_wr_en    <= 1'b1;
                  r_addr     <= r_base + r_accepted[ADDR_WIDTH-1:0];
                  r_data     <= w_word;
                  r_accepted <= r_accepted + 1'b1;
                  r_done     <= ((r_accepted + 1'b1) == r_length);
               end else begin
                  r_err <= 1'b1;
               end
            end
         end
      end
   end

   assign o_mem_wr_en   = r_wr_en;
   assign o_mem_addr    = r_addr;
   assign o_mem_wr_data = r_data;
   assign o_done        = r_done;
   assign o_err         = r_err;
   assign o_count       = r_count;

endmodule
`default_nettype wire
